// File: rtl/tx_rx_sequencer_if.sv
// Switch input and status outputs of the TX/RX sequencer, bundled for port connection.
// slave is the sequencer side, master is the board/bench side.
interface tx_rx_sequencer_if #(
   parameter int unsigned PW = 2
);
   logic [3:0]    i_sw;
   logic          o_tx_en;
   logic          o_tx_zero;
   logic          o_baud_tick;
   logic          o_rx_en;
   logic [PW-1:0] o_phase;
   logic [1:0]    o_state;
   logic [3:0]    o_led;

   modport slave (
      input  i_sw,
      output o_tx_en, o_tx_zero, o_baud_tick, o_rx_en, o_phase, o_state, o_led
   );

   modport master (
      output i_sw,
      input  o_tx_en, o_tx_zero, o_baud_tick, o_rx_en, o_phase, o_state, o_led
   );
endinterface

// File: rtl/tx_rx_sequencer.sv
// Baud-aligned TX/RX sequencer: IDLE -> WARMUP -> RUN -> FLUSH -> IDLE, with
// synchronized switch inputs, baud strobe and downsampling phase select.
module tx_rx_sequencer #(
   parameter int unsigned NBAUDS = 6,
   parameter int unsigned OS     = 4,
   parameter int unsigned PW     = 2
) (
   input  logic              clock,
   input  logic              i_reset,
   tx_rx_sequencer_if.slave  io_seq
);

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_WARMUP = 2'b01;
   localparam logic [1:0] ST_RUN    = 2'b10;
   localparam logic [1:0] ST_FLUSH  = 2'b11;

   localparam int unsigned    BW        = (NBAUDS > 1) ? $clog2(NBAUDS) : 1;
   localparam logic [PW-1:0]  OS_LAST   = PW'(OS - 1);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(NBAUDS - 1);

   logic [3:0]    r_sw_meta;
   logic [3:0]    r_sw_s;
   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [PW-1:0] r_os_cnt;
   logic [PW-1:0] w_os_nxt;
   logic [BW-1:0] r_baud_cnt;
   logic [BW-1:0] w_baud_nxt;
   logic [PW-1:0] r_phase;
   logic [PW-1:0] w_phase_nxt;
   logic [PW-1:0] w_phase_sel;
   logic [31:0]   w_sel;
   logic          w_bnd;

   assign w_bnd = (r_state != ST_IDLE) && (r_os_cnt == OS_LAST);

   // Requested phase is clamped so it never names a sample outside the baud.
   assign w_sel       = {30'd0, r_sw_s[3:2]};
   assign w_phase_sel = (w_sel > (OS - 1)) ? OS_LAST : PW'(w_sel);

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud_cnt;
      case (r_state)
         ST_IDLE: begin
            if (r_sw_s[0]) w_state_nxt = ST_WARMUP;
         end
         ST_WARMUP: begin
            // Shutdown request wins over warm-up completion at the same boundary.
            if (w_bnd) begin
               if (!r_sw_s[0])                    w_state_nxt = ST_FLUSH;
               else if (r_baud_cnt == BAUD_LAST)  w_state_nxt = ST_RUN;
               else                               w_baud_nxt  = r_baud_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (w_bnd && !r_sw_s[0]) w_state_nxt = ST_FLUSH;
         end
         default: begin
            if (w_bnd) begin
               if (r_baud_cnt == BAUD_LAST) w_state_nxt = ST_IDLE;
               else                         w_baud_nxt  = r_baud_cnt + 1'b1;
            end
         end
      endcase
      if (w_state_nxt != r_state) w_baud_nxt = '0;
   end

   always_comb begin
      w_os_nxt = '0;
      if (r_state != ST_IDLE && r_os_cnt != OS_LAST) w_os_nxt = r_os_cnt + 1'b1;
   end

   assign w_phase_nxt = w_bnd ? w_phase_sel : r_phase;

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         r_sw_meta  <= '0;
         r_sw_s     <= '0;
         r_state    <= ST_IDLE;
         r_os_cnt   <= '0;
         r_baud_cnt <= '0;
         r_phase    <= '0;
      end else begin
         r_sw_meta  <= io_seq.i_sw;
         r_sw_s     <= r_sw_meta;
         r_state    <= w_state_nxt;
         r_os_cnt   <= w_os_nxt;
         r_baud_cnt <= w_baud_nxt;
         r_phase    <= w_phase_nxt;
      end
   end

   assign io_seq.o_tx_en     = (r_state != ST_IDLE);
   assign io_seq.o_tx_zero   = (r_state == ST_FLUSH);
   assign io_seq.o_baud_tick = (r_state != ST_IDLE) && (r_os_cnt == '0);
   assign io_seq.o_rx_en     = (r_state == ST_RUN) && r_sw_s[1];
   assign io_seq.o_phase     = r_phase;
   assign io_seq.o_state     = r_state;
   assign io_seq.o_led       = {(r_state == ST_FLUSH), (r_state == ST_RUN),
                                io_seq.o_rx_en, io_seq.o_tx_en};

endmodule

// File: doc/tx_rx_sequencer.md
TX_RX_SEQUENCER -- requirements
Module: tx_rx_sequencer

Interface
REQ-001 Parameter NBAUDS, default 6: filter span in bauds; sets the warm-up and flush lengths.
REQ-002 Parameter OS, default 4: oversampling factor in clocks per baud; legal range 2..16.
REQ-003 Parameter PW, default 2: o_phase width; equals clog2(OS).
REQ-004 Port clock, input, 1: system clock; all logic on the rising edge.
REQ-005 Port i_reset, input, 1: reset, asynchronous and active-low.
REQ-006 Port i_sw, input, 4: board switches, asynchronous; [0] tx enable, [1] rx enable, [3:2] phase select.
REQ-007 Port o_tx_en, output, 1: enables PRBS and TX filter advance.
REQ-008 Port o_tx_zero, output, 1: forces zero symbols into the TX filter (flush).
REQ-009 Port o_baud_tick, output, 1: single-cycle strobe at the first clock of each baud.
REQ-010 Port o_rx_en, output, 1: enables downsampler and BER checker.
REQ-011 Port o_phase, output, PW: downsampling phase, 0..OS-1.
REQ-012 Port o_state, output, 2: FSM state; IDLE=00, WARMUP=01, RUN=10, FLUSH=11.
REQ-013 Port o_led, output, 4: {state==FLUSH, state==RUN, o_rx_en, o_tx_en}, MSB first.

Function
REQ-014 i_sw SHALL pass through a 2-flop synchronizer (sw_s) before any use; this adds 2 clocks of latency.
REQ-015 os_cnt (0..OS-1) SHALL be held at 0 in IDLE, increment every clock in other states, and wrap OS-1 -> 0.
REQ-016 A baud boundary SHALL be a clock with os_cnt==OS-1 and state!=IDLE.
REQ-017 o_baud_tick SHALL be 1 iff state!=IDLE and os_cnt==0, giving exactly one tick per OS clocks.
REQ-018 baud_cnt SHALL count baud boundaries in WARMUP and FLUSH, clear on every state change, and be held at 0 in RUN.
REQ-019 IDLE -> WARMUP on the first clock with sw_s[0]=1.
REQ-020 WARMUP -> RUN at the baud boundary that completes NBAUDS bauds, i.e. NBAUDS*OS clocks after entry.
REQ-021 WARMUP or RUN -> FLUSH at the first baud boundary with sw_s[0]=0; a partial baud is never truncated.
REQ-022 FLUSH -> IDLE at the baud boundary completing NBAUDS bauds.
REQ-023 sw_s[0] returning to 1 during FLUSH SHALL NOT abort the flush; IDLE then re-enters WARMUP on the next clock.
REQ-024 o_tx_en = (state!=IDLE).
REQ-025 o_tx_zero = (state==FLUSH).
REQ-026 o_rx_en = (state==RUN) & sw_s[1]; it is combinational from registered state and sw_s and may toggle at any clock in RUN.
REQ-027 o_phase SHALL load min(sw_s[3:2], OS-1) only at baud boundaries and hold at all other times, so the phase never changes mid-baud.
REQ-028 When two events coincide at a boundary, the FLUSH request (sw_s[0]=0) SHALL take priority over WARMUP completion.
REQ-029 All outputs SHALL be glitch-free functions of registers only.

Reset
REQ-030 Asserting i_reset=0 at any time SHALL immediately force state=IDLE, os_cnt=0, baud_cnt=0, o_phase=0 and synchronizer flops=0, with no clock required.
REQ-031 While reset is asserted and after release, outputs SHALL read o_tx_en=0, o_tx_zero=0, o_baud_tick=0, o_rx_en=0, o_phase=0, o_state=00, o_led=0000.
REQ-032 The first state change SHALL be no earlier than the 3rd clock after reset release with i_sw[0]=1.

Verification
REQ-033 Startup: release reset, raise i_sw[0] at clock k -> o_state=01 and o_tx_en=1 from clock k+3, o_baud_tick every 4 clocks, o_state=10 exactly 24 clocks later.
REQ-034 RX gating: in RUN toggle i_sw[1] -> o_rx_en follows after 2 clocks; o_led[1] matches o_rx_en; i_sw[1]=1 in WARMUP -> o_rx_en stays 0.
REQ-035 Phase: in RUN set i_sw[3:2]=2'b11 mid-baud -> o_phase changes to 3 only at the next os_cnt==3 clock, never elsewhere.
REQ-036 Shutdown: drop i_sw[0] in RUN -> FLUSH at the next baud boundary, o_tx_zero=1 for exactly 24 clocks, then IDLE with o_led=0000.
REQ-037 Re-enable during flush: i_sw[0] 0->1 mid-FLUSH -> flush completes its full 24 clocks, IDLE lasts 1 clock, then WARMUP.
REQ-038 Reset mid-operation: assert i_reset=0 in RUN between clock edges -> all outputs reach their reset values asynchronously; restart then matches REQ-033.
